// File: rtl/mc_control_fsm.sv
// Main control FSM for the multicycle processor: sequences fetch/decode/execute
// for R-type, lw, sw, beq, j and addi, with memory states stretched on mem_ready.
module mc_control_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    // state    | meaning
    // FETCH    | read instruction at PC, PC += 4 when memory completes
    // DECODE   | read registers, precompute branch target
    // MEMADR   | ALUOut = A + sign-extended offset
    // MEMREAD  | load data from ALUOut into MDR
    // MEMWB    | write MDR to rt
    // MEMWRITE | store B to ALUOut
    // EXEC     | R-type ALU operation
    // ALUWB    | write ALUOut to rd
    // BRANCH   | compare A and B, take branch on zero
    // ADDIEX   | A + sign-extended immediate
    // ADDIWB   | write ALUOut to rt
    // JUMP     | load jump target into PC
    // ILLEGAL  | unsupported opcode seen, parked until reset
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    state_t state, state_nxt;
    logic   rdy;

    assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (rdy) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    default:      state_nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_nxt = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (rdy) state_nxt = S_MEMWB;
            S_MEMWRITE: if (rdy) state_nxt = S_FETCH;
            S_EXEC:     state_nxt = S_ALUWB;
            S_ADDIEX:   state_nxt = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
                        state_nxt = S_FETCH;
            S_ILLEGAL:  state_nxt = S_ILLEGAL;
            default:    state_nxt = S_ILLEGAL;
        endcase
    end

    // Moore decode; reset masks every output, including the debug state view.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_op    = 1'b0;
        state_o       = 4'd0;
        if (!rst) begin
            state_o = state;
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = rdy;
                    pc_write  = rdy;
                end
                S_DECODE:   alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMREAD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_src        = 2'b01;
                    pc_write_cond = 1'b1;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDIWB:   reg_write = 1'b1;
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
                default:    illegal_op = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction state paths and control
// words from a path-based reference model, with randomized memory stalls.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       mr_zero = 1'b0;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state_o;

    logic       nw_pc_write, nw_pc_write_cond, nw_i_or_d, nw_mem_read, nw_mem_write, nw_ir_write;
    logic       nw_mem_to_reg, nw_reg_dst, nw_reg_write, nw_alu_src_a, nw_illegal_op;
    logic [1:0] nw_pc_src, nw_alu_src_b, nw_alu_op;
    logic [3:0] nw_state_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .illegal_op(illegal_op), .state_o(state_o)
    );

    mc_control_fsm #(.MEM_WAIT_EN(1'b0)) dut_nw (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mr_zero),
        .pc_write(nw_pc_write), .pc_write_cond(nw_pc_write_cond), .pc_src(nw_pc_src),
        .i_or_d(nw_i_or_d), .mem_read(nw_mem_read), .mem_write(nw_mem_write),
        .ir_write(nw_ir_write), .mem_to_reg(nw_mem_to_reg), .reg_dst(nw_reg_dst),
        .reg_write(nw_reg_write), .alu_src_a(nw_alu_src_a), .alu_src_b(nw_alu_src_b),
        .alu_op(nw_alu_op), .illegal_op(nw_illegal_op), .state_o(nw_state_o)
    );

    // Control word: {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
    // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op}
    logic [16:0] act;
    assign act = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op};

    function automatic logic [16:0] exp_ctrl(input int s, input logic r);
        logic pw = 0, pwc = 0, ior = 0, mr = 0, mw = 0, irw = 0;
        logic m2r = 0, rd = 0, rw = 0, asa = 0, ill = 0;
        logic [1:0] ps = 2'b00, asb = 2'b00, aop = 2'b00;
        case (s)
            0:  begin mr = 1; asb = 2'b01; irw = r; pw = r; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; ior = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; ior = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; ps = 2'b01; pwc = 1; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pw = 1; ps = 2'b10; end
            default: ill = 1;
        endcase
        return {pw, pwc, ps, ior, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ill};
    endfunction

    function automatic bit is_mem_state(input int s);
        return (s == 0) || (s == 3) || (s == 5);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one instruction starting in FETCH; stalls: sf cycles in FETCH, sm in
    // MEMREAD/MEMWRITE, or random when rnd. Ends at a negedge with the next FETCH current.
    task automatic run_instr(input logic [5:0] op, input int sf, input int sm,
                             input bit rnd, output int cyc);
        int path[$];
        int idx = 0, fc = 0, mc = 0, s;
        case (op)
            6'h23:   path = '{0, 1, 2, 3, 4};
            6'h2B:   path = '{0, 1, 2, 5};
            6'h00:   path = '{0, 1, 6, 7};
            6'h08:   path = '{0, 1, 9, 10};
            6'h04:   path = '{0, 1, 8};
            default: path = '{0, 1, 11};
        endcase
        opcode = op;
        cyc = 0;
        while (idx < path.size() && cyc < 100) begin
            s = path[idx];
            if (rnd)          mem_ready = ($urandom_range(3) != 0);
            else if (s == 0)  mem_ready = (fc >= sf);
            else if (is_mem_state(s)) mem_ready = (mc >= sm);
            else              mem_ready = 1'($urandom_range(1));
            #1;
            n_checks++;
            if (state_o !== 4'(s))
                $display("FAIL state op=%h cyc=%0d got=%0d exp=%0d", op, cyc, state_o, s);
            else n_pass++;
            n_checks++;
            if (act !== exp_ctrl(s, mem_ready))
                $display("FAIL ctrl op=%h st=%0d got=%b exp=%b", op, s, act, exp_ctrl(s, mem_ready));
            else n_pass++;
            if (is_mem_state(s) && !mem_ready) begin
                if (s == 0) fc++; else mc++;
            end else idx++;
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (cyc >= 100) $display("FAIL timeout op=%h got=%0d cycles exp<100", op, cyc);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(1));
            opcode = 6'($urandom);
            #1;
            n_checks++;
            if (act !== 17'd0 || state_o !== 4'd0)
                $display("FAIL reset_outputs got=%b/%0d exp=0/0", act, state_o);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 4'd0 || mem_read !== 1'b1 || ir_write !== 1'b0)
            $display("FAIL reset_exit got st=%0d mr=%b irw=%b exp st=0 mr=1 irw=0",
                     state_o, mem_read, ir_write);
        else n_pass++;
    endtask

    task automatic test_cpi();
        logic [5:0] ops[6] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02};
        int cpi[6] = '{5, 4, 4, 4, 3, 3};
        int cyc;
        do_reset();
        foreach (ops[i]) begin
            run_instr(ops[i], 0, 0, 0, cyc);
            n_checks++;
            if (cyc !== cpi[i]) $display("FAIL cpi op=%h got=%0d exp=%0d", ops[i], cyc, cpi[i]);
            else n_pass++;
        end
    endtask

    task automatic test_fetch_wait();
        int cyc;
        do_reset();
        run_instr(6'h23, 3, 0, 0, cyc);
        n_checks++;
        if (cyc !== 8) $display("FAIL fetch_wait_cycles got=%0d exp=8", cyc);
        else n_pass++;
    endtask

    task automatic test_sw_wait();
        int cyc;
        do_reset();
        run_instr(6'h2B, 0, 2, 0, cyc);
        n_checks++;
        if (cyc !== 6) $display("FAIL sw_wait_cycles got=%0d exp=6", cyc);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_reset();
        run_instr(6'h04, 0, 0, 0, cyc);
        run_instr(6'h02, 0, 0, 0, cyc);
        run_instr(6'h00, 0, 0, 0, cyc);
    endtask

    task automatic test_random();
        logic [5:0] ops[6] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02};
        int cyc;
        do_reset();
        for (int i = 0; i < 60; i++)
            run_instr(ops[$urandom_range(5)], 0, 0, 1, cyc);
    endtask

    task automatic test_illegal(input logic [5:0] op);
        do_reset();
        opcode = op;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            mem_ready = 1'($urandom_range(1));
            opcode = 6'($urandom);
            #1;
            n_checks++;
            if (state_o !== 4'd12 || act !== exp_ctrl(12, mem_ready))
                $display("FAIL illegal_hold op=%h i=%0d got st=%0d ctrl=%b exp st=12", op, i, state_o, act);
            else n_pass++;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (act !== 17'd0 || state_o !== 4'd0)
            $display("FAIL illegal_rst got=%b/%0d exp=0/0", act, state_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 4'd0 || illegal_op !== 1'b0 || mem_read !== 1'b1)
            $display("FAIL illegal_clear got st=%0d ill=%b mr=%b exp st=0 ill=0 mr=1",
                     state_o, illegal_op, mem_read);
        else n_pass++;
    endtask

    // Parks in the memory state of lw/sw with mem_ready low, then resets.
    task automatic test_reset_mid(input logic [5:0] op, input int mem_st);
        int cyc;
        do_reset();
        opcode = op;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (state_o !== 4'(mem_st) || act !== exp_ctrl(mem_st, 1'b0))
                $display("FAIL mid_hold op=%h got st=%0d ctrl=%b exp st=%0d", op, state_o, act, mem_st);
            else n_pass++;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (act !== 17'd0 || state_o !== 4'd0)
            $display("FAIL mid_rst op=%h got=%b/%0d exp=0/0", op, act, state_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 4'd0 || mem_read !== 1'b1 || mem_write !== 1'b0)
            $display("FAIL mid_resume op=%h got st=%0d mr=%b mw=%b exp st=0 mr=1 mw=0",
                     op, state_o, mem_read, mem_write);
        else n_pass++;
        run_instr(6'h23, 0, 1, 0, cyc);
    endtask

    task automatic test_nowait();
        int seq[6] = '{0, 1, 2, 3, 4, 0};
        do_reset();
        opcode = 6'h23;
        mem_ready = 1'b1;
        foreach (seq[i]) begin
            #1;
            n_checks++;
            if (nw_state_o !== 4'(seq[i]) ||
                nw_mem_read !== (seq[i] == 0 || seq[i] == 3) ||
                nw_ir_write !== (seq[i] == 0) ||
                nw_reg_write !== (seq[i] == 4))
                $display("FAIL nowait i=%0d got st=%0d mr=%b irw=%b rw=%b exp st=%0d",
                         i, nw_state_o, nw_mem_read, nw_ir_write, nw_reg_write, seq[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_cpi();
        test_fetch_wait();
        test_sw_wait();
        test_back_to_back();
        test_illegal(6'h3F);
        test_illegal(6'h11);
        test_reset_mid(6'h23, 3);
        test_reset_mid(6'h2B, 5);
        test_nowait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Main control state machine for the multicycle processor. Sequences the shared datapath (PC, instruction register, A/B operand registers, ALUOut and memory-data registers, register file, ALU, unified memory) over several cycles per instruction for the subset R-type, lw, sw, beq, j and addi. Emits Moore-style control strobes and ALU/mux selects from the current state. Stretches memory states on a memory-ready handshake.

## Interface
- MEM_WAIT_EN, 1: when 1, memory states wait for mem_ready; when 0, mem_ready is ignored and treated as 1.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register; sampled only in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero; the datapath performs the gating.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register-file write data: 0 ALUOut, 1 MDR.
- reg_dst  out  1  destination register: 0 rt, 1 rd.
- reg_write  out  1  register-file write.
- alu_src_a  out  1  0 PC, 1 A.
- alu_src_b  out  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left by 2.
- alu_op  out  2  00 add, 01 subtract, 10 use funct field.
- illegal_op  out  1  sticky flag for an unsupported opcode.
- state_o  out  4  current state encoding, for debug.

## Operation
State encodings and outputs (any output not listed is 0):
- FETCH (0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_write are 1 only in a cycle where mem_ready=1.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00.
- MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=00.
- MEMREAD (3): mem_read=1, i_or_d=1.
- MEMWB (4): reg_write=1, reg_dst=0, mem_to_reg=1.
- MEMWRITE (5): mem_write=1, i_or_d=1.
- EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=10.
- ALUWB (7): reg_write=1, reg_dst=1, mem_to_reg=0.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond=1.
- ADDIEX (9): alu_src_a=1, alu_src_b=10, alu_op=00.
- ADDIWB (10): reg_write=1, reg_dst=0, mem_to_reg=0.
- JUMP (11): pc_write=1, pc_src=10.
- ILLEGAL (12): illegal_op=1; all strobes 0.

Transitions:
- FETCH: to DECODE if mem_ready=1, otherwise hold.
- DECODE, by opcode:
  - 0x00 to EXEC.
  - 0x23 or 0x2B to MEMADR.
  - 0x04 to BRANCH.
  - 0x02 to JUMP.
  - 0x08 to ADDIEX.
  - any other value to ILLEGAL.
- MEMADR: to MEMREAD for opcode 0x23, to MEMWRITE for 0x2B. The opcode is stable because ir_write is 0 outside FETCH.
- MEMREAD: to MEMWB if mem_ready=1, otherwise hold. mem_read stays asserted while holding.
- MEMWRITE: to FETCH if mem_ready=1, otherwise hold. mem_write stays asserted while holding.
- EXEC to ALUWB; ADDIEX to ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH and JUMP: to FETCH.
- ILLEGAL: hold until rst.
- Unused encodings 13–15: go to ILLEGAL on the next clock; outputs decode as ILLEGAL.

## Timing
- Reset:
  - rst=1 at a posedge loads state FETCH.
  - While rst=1, every output is forced to 0, including illegal_op and mem_read; state_o reads 0.
  - The first cycle with rst=0 is FETCH with mem_read=1.
- Reset mid-instruction (any state, including a held memory state): the next state is FETCH and no further strobes are issued. An in-flight write is abandoned; mem_write drops in the cycle rst is sampled high.
- Cycles per instruction with mem_ready held at 1:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each cycle mem_ready=0 adds one cycle in FETCH, MEMREAD or MEMWRITE.
- Handshake: a memory access completes in the cycle where the request is high and mem_ready=1. mem_ready has no effect in any other state.
- All outputs depend only on the current state, plus mem_ready in FETCH (the ir_write and pc_write gating). There is no combinational path from opcode to any output.
- The transition out of DECODE uses opcode as sampled in DECODE.

## Test plan
- Reset, then lw (opcode 0x23), mem_ready=1 throughout: state_o sequence 0,1,2,3,4,0. reg_write=1 with mem_to_reg=1 only in the fifth cycle. ir_write=1 only in the first cycle.
- FETCH wait with MEM_WAIT_EN=1: mem_ready low for 3 cycles, then high. state_o stays 0 for 4 cycles. ir_write and pc_write pulse once, in cycle 4. mem_read is high for all 4 cycles.
- sw (0x2B) with mem_ready low for 2 cycles in MEMWRITE: state_o sequence 0,1,2,5,5,5,0. mem_write is high for all three MEMWRITE cycles. reg_write is never 1.
- beq (0x04), then j (0x02), then R-type (0x00): state_o sequence 0,1,8 / 0,1,11 / 0,1,6,7. pc_write_cond=1 only in state 8. pc_write=1 in state 11. alu_op=10 in state 6.
- Opcode 0x3F: DECODE goes to ILLEGAL and illegal_op=1 is held for 20 or more cycles. rst=1 for one cycle clears it and the next cycle is FETCH.
- rst asserted while held in MEMREAD: next state_o is 0, all strobes are 0 during reset, and normal fetch resumes afterwards. Repeat the lw case with MEM_WAIT_EN=0 and mem_ready tied low: it still completes in 5 cycles.
